map_wr_arbiter: RTL and testbench

Parametrised N-channel write arbiter and buffer in front of the map memory's single write port. It replaces the fixed 4-way priority mux on `we`/`wr_addr`/`write_data`. Each writer (bomb placement, block freeing, future power-up/exit writers) gets a small per-channel FIFO, so single-cycle write pulses are never lost when several writers fire together. One buffered write per cycle is forwarded to `map_mem`; `power_up` snoops the same registered stream.

---
 rtl/map_wr_arbiter_pkg.sv | 16 +
 rtl/map_wr_arbiter_if.sv | 40 ++++
 rtl/map_wr_arbiter_wr_fifo.sv | 73 +++++++
 rtl/map_wr_arbiter.sv | 156 +++++++++++++++
 tb/tb_map_wr_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/map_wr_arbiter_pkg.sv
// Shared map-block types plus helpers local to the map write arbiter.

package bomberman_pkg;
  // Arbitration policy for shared write ports.
  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,  // round-robin, search starts at the rotating pointer
    ARB_FIXED = 1'b1   // lowest channel index always wins
  } arb_mode_t;
endpackage

package map_wr_arbiter_pkg;
  // Width of a channel index; a single channel still needs one bit.
  function automatic int src_width(input int num_wr);
    return (num_wr > 1) ? $clog2(num_wr) : 1;
  endfunction
endpackage

// File: rtl/map_wr_arbiter_if.sv
// Writer-side request bus and map_mem-side write stream of the arbiter.

interface map_wr_arbiter_if #(
  parameter int NUM_WR     = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
);
  import map_wr_arbiter_pkg::*;

  localparam int SRC_W = src_width(NUM_WR);

  // Per-channel write requests (single-cycle pulses from the writers).
  logic                  wr_en_in   [0:NUM_WR-1];
  logic [ADDR_WIDTH-1:0] wr_addr_in [0:NUM_WR-1];
  logic [DATA_WIDTH-1:0] wr_data_in [0:NUM_WR-1];

  // Per-channel status.
  logic                  ch_ready   [0:NUM_WR-1];
  logic                  overflow   [0:NUM_WR-1];

  // Registered write stream towards map_mem / power_up.
  logic                  map_we;
  logic [ADDR_WIDTH-1:0] map_wr_addr;
  logic [DATA_WIDTH-1:0] map_wr_data;
  logic [SRC_W-1:0]      map_wr_src;

  // Writers side: drives requests, observes status and the write stream.
  modport master (
    output wr_en_in, wr_addr_in, wr_data_in,
    input  ch_ready, overflow,
    input  map_we, map_wr_addr, map_wr_data, map_wr_src
  );

  // Arbiter side.
  modport slave (
    input  wr_en_in, wr_addr_in, wr_data_in,
    output ch_ready, overflow,
    output map_we, map_wr_addr, map_wr_data, map_wr_src
  );
endinterface

// File: rtl/map_wr_arbiter_wr_fifo.sv
// Small single-clock FIFO for one writer channel. When empty, the incoming
// entry is visible on o_head in the same cycle so it can be granted at once
// without ever being stored.

module wr_fifo #(
  parameter int DEPTH = 2,   // power of two, >= 2
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_bypass;
  logic w_wr;
  logic w_rd;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_push_acc = i_push && (!w_full || i_pop);
  // Pop is only meaningful when there is a head (stored or bypassed).
  assign w_pop_acc  = i_pop && (!w_empty || i_push);
  // Empty + push + pop: the entry passes straight through, nothing is stored.
  assign w_bypass   = w_empty && w_push_acc && w_pop_acc;
  assign w_wr       = w_push_acc && !w_bypass && !i_flush;
  assign w_rd       = w_pop_acc && !w_empty;

  assign o_head  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush behaves like a local reset.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end
endmodule

// File: rtl/map_wr_arbiter.sv
// N-channel write arbiter in front of the map memory's single write port.
// Each writer gets a small FIFO; one entry per cycle is granted and
// registered onto the map_* write stream.

module map_wr_arbiter
  import bomberman_pkg::*, map_wr_arbiter_pkg::*;
#(
  parameter int        NUM_WR     = 4,
  parameter int        ADDR_WIDTH = 8,
  parameter int        DATA_WIDTH = 2,
  parameter int        FIFO_DEPTH = 2,
  parameter arb_mode_t ARB_MODE   = ARB_RR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          game_over,
  map_wr_arbiter_if.slave bus
);
  localparam int SRC_W = src_width(NUM_WR);
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [NUM_WR-1:0] w_push;
  logic [NUM_WR-1:0] w_pop;
  logic [NUM_WR-1:0] w_full;
  logic [NUM_WR-1:0] w_empty;
  logic [NUM_WR-1:0] w_req;
  logic [ENT_W-1:0]  w_head [0:NUM_WR-1];

  logic [NUM_WR-1:0] w_req_rot;
  logic              w_grant_vld;
  logic [SRC_W-1:0]  w_grant_idx;
  logic [SRC_W-1:0]  w_next_ptr;
  logic [ENT_W-1:0]  w_sel_head;
  int                w_rot_idx;
  int                w_sum;

  logic [SRC_W-1:0]      r_rr_ptr;
  logic                  r_map_we;
  logic [ADDR_WIDTH-1:0] r_map_wr_addr;
  logic [DATA_WIDTH-1:0] r_map_wr_data;
  logic [SRC_W-1:0]      r_map_wr_src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_ch
      logic r_overflow;

      // game_over blocks new entries; the FIFO is flushed at the same time.
      assign w_push[gi] = bus.wr_en_in[gi] && !game_over;
      assign w_pop[gi]  = w_grant_vld && (w_grant_idx == SRC_W'(gi));
      // A channel can be granted if it holds data or is being written now.
      assign w_req[gi]  = !w_empty[gi] || w_push[gi];

      wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (game_over),
        .i_push  (w_push[gi]),
        .i_pop   (w_pop[gi]),
        .i_data  ({bus.wr_addr_in[gi], bus.wr_data_in[gi]}),
        .o_head  (w_head[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi])
      );

      // Sticky drop flag: a push into a full FIFO that is not draining now.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_overflow <= 1'b0;
        end else if (w_push[gi] && w_full[gi] && !w_pop[gi]) begin
          r_overflow <= 1'b1;
        end
      end

      assign bus.ch_ready[gi] = !w_full[gi];
      assign bus.overflow[gi] = r_overflow;
    end
  endgenerate

  // Choose one requesting channel: fixed priority, or round-robin via a
  // double-width rotate of the request vector and a lowest-bit encode.
  always_comb begin
    w_req_rot   = NUM_WR'({w_req, w_req} >> r_rr_ptr);
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_rot_idx   = 0;
    w_sum       = 0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_WR - 1; i >= 0; i--) begin
        if (w_req[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SRC_W'(i);
        end
      end
    end else begin
      for (int i = NUM_WR - 1; i >= 0; i--) begin
        if (w_req_rot[i]) begin
          w_grant_vld = 1'b1;
          w_rot_idx   = i;
        end
      end
      // Undo the rotation: sum is below 2*NUM_WR so one subtract suffices.
      w_sum = w_rot_idx + int'(r_rr_ptr);
      if (w_sum >= NUM_WR) begin
        w_sum = w_sum - NUM_WR;
      end
      w_grant_idx = SRC_W'(w_sum);
    end
    if (game_over) begin
      w_grant_vld = 1'b0;
    end
  end

  // Head entry of the granted channel and the pointer value after this grant.
  always_comb begin
    w_sel_head = w_head[w_grant_idx];
    w_next_ptr = w_grant_idx + SRC_W'(1);
    if (int'(w_grant_idx) == NUM_WR - 1) begin
      w_next_ptr = '0;
    end
  end

  // Round-robin pointer: moves past each granted channel, parks otherwise.
  always_ff @(posedge clk) begin
    if (rst || game_over) begin
      r_rr_ptr <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  // Registered write stream; address/data/source hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_map_we      <= 1'b0;
      r_map_wr_addr <= '0;
      r_map_wr_data <= '0;
      r_map_wr_src  <= '0;
    end else if (w_grant_vld) begin
      r_map_we      <= 1'b1;
      r_map_wr_addr <= w_sel_head[ENT_W-1:DATA_WIDTH];
      r_map_wr_data <= w_sel_head[DATA_WIDTH-1:0];
      r_map_wr_src  <= w_grant_idx;
    end else begin
      r_map_we      <= 1'b0;
    end
  end

  assign bus.map_we      = r_map_we;
  assign bus.map_wr_addr = r_map_wr_addr;
  assign bus.map_wr_data = r_map_wr_data;
  assign bus.map_wr_src  = r_map_wr_src;
endmodule

// File: tb/tb_map_wr_arbiter.sv
// Directed bench for map_wr_arbiter: one round-robin and one fixed-priority
// instance, expected writes queued per instance and matched as they emerge.
`timescale 1ns/1ps

module tb_map_wr_arbiter;
  import bomberman_pkg::*;

  localparam int NW = 4;
  localparam int AW = 8;
  localparam int DW = 2;
  localparam int SW = 2;

  typedef logic [AW+DW+SW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst;
  logic game_over;

  always #5 clk = ~clk;

  map_wr_arbiter_if #(.NUM_WR(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
  map_wr_arbiter_if #(.NUM_WR(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fx ();

  map_wr_arbiter #(
    .NUM_WR(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(2), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk(clk), .rst(rst), .game_over(game_over), .bus(bus_rr)
  );

  map_wr_arbiter #(
    .NUM_WR(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(2), .ARB_MODE(ARB_FIXED)
  ) dut_fx (
    .clk(clk), .rst(rst), .game_over(game_over), .bus(bus_fx)
  );

  ent_t q_rr[$];
  ent_t q_fx[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ent(input logic [7:0] a, input logic [1:0] d, input int s);
    return {a, d, 2'(s)};
  endfunction

  task automatic drv_rr(input int ch, input logic [7:0] a, input logic [1:0] d);
    bus_rr.wr_en_in[ch]   = 1'b1;
    bus_rr.wr_addr_in[ch] = a;
    bus_rr.wr_data_in[ch] = d;
  endtask

  task automatic drv_fx(input int ch, input logic [7:0] a, input logic [1:0] d);
    bus_fx.wr_en_in[ch]   = 1'b1;
    bus_fx.wr_addr_in[ch] = a;
    bus_fx.wr_data_in[ch] = d;
  endtask

  task automatic clear_in();
    for (int i = 0; i < NW; i++) begin
      bus_rr.wr_en_in[i] = 1'b0;
      bus_fx.wr_en_in[i] = 1'b0;
    end
  endtask

  function automatic logic [NW-1:0] rdy_rr();
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = bus_rr.ch_ready[i];
    return v;
  endfunction

  function automatic logic [NW-1:0] ovf_rr();
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = bus_rr.overflow[i];
    return v;
  endfunction

  function automatic logic [NW-1:0] rdy_fx();
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = bus_fx.ch_ready[i];
    return v;
  endfunction

  function automatic logic [NW-1:0] ovf_fx();
    logic [NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i] = bus_fx.overflow[i];
    return v;
  endfunction

  // Advance one clock, then match any emerging write against the scoreboard.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    #1;
    if (bus_rr.map_we === 1'b1) begin
      if (q_rr.size() == 0) begin
        check("rr_unexpected_we", 32'(bus_rr.map_we), 32'd0);
      end else begin
        e = q_rr.pop_front();
        check("rr_write", 32'({bus_rr.map_wr_addr, bus_rr.map_wr_data, bus_rr.map_wr_src}), 32'(e));
      end
    end
    if (bus_fx.map_we === 1'b1) begin
      if (q_fx.size() == 0) begin
        check("fx_unexpected_we", 32'(bus_fx.map_we), 32'd0);
      end else begin
        e = q_fx.pop_front();
        check("fx_write", 32'({bus_fx.map_wr_addr, bus_fx.map_wr_data, bus_fx.map_wr_src}), 32'(e));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles with random requests present.
    rst       = 1'b1;
    game_over = 1'b0;
    for (int i = 0; i < NW; i++) begin
      bus_rr.wr_en_in[i]   = 1'($urandom_range(0, 1));
      bus_rr.wr_addr_in[i] = 8'($urandom);
      bus_rr.wr_data_in[i] = 2'($urandom);
      bus_fx.wr_en_in[i]   = 1'($urandom_range(0, 1));
      bus_fx.wr_addr_in[i] = 8'($urandom);
      bus_fx.wr_data_in[i] = 2'($urandom);
    end
    tick();
    tick();
    rst = 1'b0;
    clear_in();
    check("rst_we",       32'(bus_rr.map_we),      32'd0);
    check("rst_addr",     32'(bus_rr.map_wr_addr), 32'd0);
    check("rst_data",     32'(bus_rr.map_wr_data), 32'd0);
    check("rst_src",      32'(bus_rr.map_wr_src),  32'd0);
    check("rst_overflow", 32'(ovf_rr()),           32'd0);
    check("rst_ready",    32'(rdy_rr()),           32'hF);
    check("rst_fx_we",    32'(bus_fx.map_we),      32'd0);
    check("rst_fx_ready", 32'(rdy_fx()),           32'hF);

    // Single write latency on channel 2.
    drv_rr(2, 8'h2A, 2'b01);
    q_rr.push_back(ent(8'h2A, 2'b01, 2));
    tick();
    clear_in();
    check("lat_we_t1", 32'(bus_rr.map_we),     32'd1);
    check("lat_src",   32'(bus_rr.map_wr_src), 32'd2);
    tick();
    check("lat_we_t2", 32'(bus_rr.map_we),      32'd0);
    check("hold_addr", 32'(bus_rr.map_wr_addr), 32'h2A);
    check("hold_src",  32'(bus_rr.map_wr_src),  32'd2);

    // Grant channel 3 so the pointer wraps to 0.
    drv_rr(3, 8'h33, 2'b11);
    q_rr.push_back(ent(8'h33, 2'b11, 3));
    tick();
    clear_in();
    tick();

    // All four channels together from pointer 0: 10, 11, 12, 13.
    for (int i = 0; i < NW; i++) begin
      drv_rr(i, 8'(10 + i), 2'(i));
      q_rr.push_back(ent(8'(10 + i), 2'(i), i));
    end
    for (int k = 0; k < NW; k++) begin
      tick();
      clear_in();
      check("rr0_we_burst", 32'(bus_rr.map_we), 32'd1);
    end
    tick();
    check("rr0_we_end", 32'(bus_rr.map_we), 32'd0);

    // Grant channel 1 so the pointer moves to 2.
    drv_rr(1, 8'h21, 2'b10);
    q_rr.push_back(ent(8'h21, 2'b10, 1));
    tick();
    clear_in();
    tick();

    // All four again from pointer 2: 12, 13, 10, 11.
    for (int i = 0; i < NW; i++) drv_rr(i, 8'(10 + i), 2'(i));
    q_rr.push_back(ent(8'd12, 2'd2, 2));
    q_rr.push_back(ent(8'd13, 2'd3, 3));
    q_rr.push_back(ent(8'd10, 2'd0, 0));
    q_rr.push_back(ent(8'd11, 2'd1, 1));
    for (int k = 0; k < NW; k++) begin
      tick();
      clear_in();
      check("rr2_we_burst", 32'(bus_rr.map_we), 32'd1);
    end
    tick();
    check("rr2_we_end", 32'(bus_rr.map_we), 32'd0);

    // Fixed priority: channel 0 wins three cycles over two queued channel-3 entries.
    q_fx.push_back(ent(8'h40, 2'd0, 0));
    q_fx.push_back(ent(8'h41, 2'd1, 0));
    q_fx.push_back(ent(8'h42, 2'd2, 0));
    q_fx.push_back(ent(8'h70, 2'd1, 3));
    q_fx.push_back(ent(8'h71, 2'd2, 3));
    drv_fx(0, 8'h40, 2'd0);
    drv_fx(3, 8'h70, 2'd1);
    tick();
    check("fx_src_a", 32'(bus_fx.map_wr_src), 32'd0);
    drv_fx(0, 8'h41, 2'd1);
    drv_fx(3, 8'h71, 2'd2);
    tick();
    clear_in();
    check("fx_ch3_full", 32'(rdy_fx()), 32'h7);
    drv_fx(0, 8'h42, 2'd2);
    tick();
    clear_in();
    check("fx_src_c", 32'(bus_fx.map_wr_src), 32'd0);
    tick();
    check("fx_ch3_first", 32'(bus_fx.map_wr_src), 32'd3);
    tick();
    check("fx_ch3_second_we", 32'(bus_fx.map_we), 32'd1);
    tick();
    check("fx_idle_we", 32'(bus_fx.map_we), 32'd0);
    check("fx_no_ovf",  32'(ovf_fx()),      32'd0);

    // Overflow: channel 1 starved by channel 0, third push dropped.
    q_fx.push_back(ent(8'h80, 2'd0, 0));
    q_fx.push_back(ent(8'h81, 2'd1, 0));
    q_fx.push_back(ent(8'h82, 2'd2, 0));
    q_fx.push_back(ent(8'h91, 2'd1, 1));
    q_fx.push_back(ent(8'h92, 2'd2, 1));
    drv_fx(0, 8'h80, 2'd0);
    drv_fx(1, 8'h91, 2'd1);
    tick();
    drv_fx(0, 8'h81, 2'd1);
    drv_fx(1, 8'h92, 2'd2);
    tick();
    check("ovf_ready_full", 32'(rdy_fx()), 32'hD);
    check("ovf_not_yet",    32'(ovf_fx()), 32'd0);
    drv_fx(0, 8'h82, 2'd2);
    drv_fx(1, 8'h93, 2'd3);
    tick();
    clear_in();
    check("ovf_set", 32'(ovf_fx()), 32'h2);
    tick();
    tick();
    tick();
    check("ovf_drain_we", 32'(bus_fx.map_we), 32'd0);
    check("ovf_sticky",   32'(ovf_fx()),      32'h2);
    check("ovf_ready",    32'(rdy_fx()),      32'hF);

    // game_over: one entry leaves before the pulse, three pending are flushed.
    for (int i = 0; i < NW; i++) drv_rr(i, 8'(8'hA0 + i), 2'(i));
    q_rr.push_back(ent(8'hA2, 2'd2, 2));
    tick();
    clear_in();
    check("go_pre_we", 32'(bus_rr.map_we), 32'd1);
    game_over = 1'b1;
    tick();
    check("go_we_1", 32'(bus_rr.map_we), 32'd0);
    tick();
    check("go_we_2", 32'(bus_rr.map_we), 32'd0);
    game_over = 1'b0;
    tick();
    check("go_after_we", 32'(bus_rr.map_we), 32'd0);
    check("go_ready",    32'(rdy_rr()),      32'hF);
    check("go_ovf",      32'(ovf_rr()),      32'd0);
    drv_rr(1, 8'hB1, 2'd1);
    drv_rr(3, 8'hB3, 2'd3);
    q_rr.push_back(ent(8'hB1, 2'd1, 1));
    q_rr.push_back(ent(8'hB3, 2'd3, 3));
    tick();
    clear_in();
    check("go_next_we",  32'(bus_rr.map_we),     32'd1);
    check("go_next_src", 32'(bus_rr.map_wr_src), 32'd1);
    tick();
    check("go_next2_src", 32'(bus_rr.map_wr_src), 32'd3);
    tick();
    check("go_next_end", 32'(bus_rr.map_we), 32'd0);

    // Reset mid-operation discards pending entries.
    for (int i = 0; i < NW; i++) drv_rr(i, 8'(8'hC0 + i), 2'(i));
    q_rr.push_back(ent(8'hC0, 2'd0, 0));
    tick();
    clear_in();
    check("mrst_pre_we", 32'(bus_rr.map_we), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_we",   32'(bus_rr.map_we),      32'd0);
    check("mrst_addr", 32'(bus_rr.map_wr_addr), 32'd0);
    tick();
    check("mrst_after_we", 32'(bus_rr.map_we), 32'd0);
    tick();
    check("mrst_after2_we", 32'(bus_rr.map_we), 32'd0);
    check("mrst_ready",     32'(rdy_rr()),      32'hF);

    check("rr_queue_empty", 32'(q_rr.size()), 32'd0);
    check("fx_queue_empty", 32'(q_fx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
